// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program-counter / instruction-fetch sequencer. Walks each
//               instruction through FETCH -> DECODE -> EXEC. It faults to
//               HALT on a memory ack timeout, and it also halts on opcode 4'hF.
// Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  output logic [3:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  input  logic [3:0] next_pc,
  input  logic       stall,
  output logic [3:0] pc,
  output logic       add,
  output logic       li,
  output logic [3:0] addr,
  output logic       empty_inst,
  output logic       exec_valid,
  output logic       halted,
  output logic       fetch_err,
  output logic [7:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  // The last no-ack FETCH cycle before the timeout fires. The counter holds
  // the number of FETCH cycles that have already gone by without an ack.
  localparam logic [3:0] c_wait_last = 4'(MAX_WAIT - 1);
  localparam logic [3:0] c_op_nop    = 4'h0;
  localparam logic [3:0] c_op_add    = 4'h1;
  localparam logic [3:0] c_op_li     = 4'h2;
  localparam logic [3:0] c_op_halt   = 4'hF;

  state_t     r_state;
  logic [3:0] r_pc;
  logic [7:0] r_ir;
  logic [3:0] r_wait;
  logic [7:0] r_retired;
  logic       r_fetch_err;

  logic       w_active;
  logic [3:0] w_opcode;

  // Sequencer: the state, PC, instruction register, wait counter and retire count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= 4'h0;
      r_ir        <= 8'h00;
      r_wait      <= 4'h0;
      r_retired   <= 8'h00;
      r_fetch_err <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // If the ack arrives in the final allowed cycle, the ack takes priority over the timeout.
          if (imem_ack) begin
            r_ir    <= imem_data;
            r_wait  <= 4'h0;
            r_state <= S_DECODE;
          end else if (r_wait == c_wait_last) begin
            r_fetch_err <= 1'b1;
            r_state     <= S_HALT;
          end else begin
            r_wait <= r_wait + 4'h1;
          end
        end
        S_DECODE: begin
          r_state <= (r_ir[7:4] == c_op_halt) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          if (!stall) begin
            r_pc      <= next_pc;
            r_retired <= (r_retired == 8'hFF) ? 8'hFF : r_retired + 8'h01;
            r_wait    <= 4'h0;
            r_state   <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign w_active = (r_state == S_DECODE) || (r_state == S_EXEC);
  assign w_opcode = r_ir[7:4];

  // Decode strobes are valid only while an instruction is in flight.
  always_comb begin
    add        = 1'b0;
    li         = 1'b0;
    addr       = 4'h0;
    empty_inst = 1'b0;
    if (w_active) begin
      addr = r_ir[3:0];
      case (w_opcode)
        c_op_add:  add = 1'b1;
        c_op_li:   li  = 1'b1;
        c_op_halt: empty_inst = 1'b0;
        c_op_nop:  empty_inst = 1'b1;
        default:   empty_inst = 1'b1;
      endcase
    end
  end

  assign imem_req   = (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign exec_valid = (r_state == S_EXEC);
  assign halted     = (r_state == S_HALT);
  assign fetch_err  = r_fetch_err;
  assign retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit. Every expected
//               value in it was worked out by hand.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic       clk;
  logic       rst;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [3:0] next_pc;
  logic       stall;
  logic [3:0] pc;
  logic       add;
  logic       li;
  logic [3:0] addr;
  logic       empty_inst;
  logic       exec_valid;
  logic       halted;
  logic       fetch_err;
  logic [7:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_unit #(.MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .next_pc    (next_pc),
    .stall      (stall),
    .pc         (pc),
    .add        (add),
    .li         (li),
    .addr       (addr),
    .empty_inst (empty_inst),
    .exec_valid (exec_valid),
    .halted     (halted),
    .fetch_err  (fetch_err),
    .retired    (retired)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence never reaches its end.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Move one clock edge forward. Outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Run one whole instruction from FETCH and check the decode strobes in DECODE and EXEC.
  task automatic do_instr(input string tag, input logic [7:0] data, input logic [3:0] npc,
                          input logic e_add, input logic e_li, input logic e_empty);
    imem_ack  = 1'b1;
    imem_data = data;
    next_pc   = npc;
    tick();
    imem_ack  = 1'b0;
    check({tag, "_dec_add"},   32'(add),        32'(e_add));
    check({tag, "_dec_li"},    32'(li),         32'(e_li));
    check({tag, "_dec_empty"}, 32'(empty_inst), 32'(e_empty));
    check({tag, "_dec_addr"},  32'(addr),       32'(data[3:0]));
    check({tag, "_dec_req"},   32'(imem_req),   0);
    tick();
    check({tag, "_ex_valid"},  32'(exec_valid), 1);
    check({tag, "_ex_empty"},  32'(empty_inst), 32'(e_empty));
    tick();
    check({tag, "_pc"},        32'(pc),         32'(npc));
    check({tag, "_fetch_req"}, 32'(imem_req),   1);
    check({tag, "_fetch_adr"}, 32'(imem_addr),  32'(npc));
  endtask

  // Run one instruction without checks; used to set up state.
  task automatic quiet_instr(input logic [7:0] data, input logic [3:0] npc);
    imem_ack  = 1'b1;
    imem_data = data;
    next_pc   = npc;
    tick();
    imem_ack  = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    next_pc   = 4'h0;
    stall     = 1'b0;
    tick();
    do_reset();

    // Reset state
    check("rst_req",   32'(imem_req),   1);
    check("rst_addr",  32'(imem_addr),  0);
    check("rst_exec",  32'(exec_valid), 0);
    check("rst_add",   32'(add),        0);
    check("rst_li",    32'(li),         0);
    check("rst_empty", 32'(empty_inst), 0);
    check("rst_ret",   32'(retired),    0);
    check("rst_err",   32'(fetch_err),  0);
    check("rst_halt",  32'(halted),     0);

    // ADD, an undefined opcode, NOP, then LI
    do_instr("add15", 8'h15, 4'h1, 1'b1, 1'b0, 1'b0);
    check("add15_ret", 32'(retired), 1);
    do_instr("und07", 8'h07, 4'h2, 1'b0, 1'b0, 1'b1);
    do_instr("nop00", 8'h00, 4'h3, 1'b0, 1'b0, 1'b1);
    do_instr("li2a",  8'h2A, 4'h4, 1'b0, 1'b1, 1'b0);
    check("li2a_ret", 32'(retired), 4);

    // Stall EXEC for 5 cycles. Acks that arrive during the stall must be ignored.
    imem_ack  = 1'b1;
    imem_data = 8'h11;
    next_pc   = 4'hA;
    tick();
    imem_ack = 1'b0;
    stall    = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(exec_valid), 1);
      check("stall_pc",    32'(pc),         4);
      check("stall_ret",   32'(retired),    4);
      check("stall_add",   32'(add),        1);
      imem_ack  = 1'b1;
      imem_data = 8'hF0;
      tick();
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    check("stall_valid6", 32'(exec_valid), 1);
    check("stall_ir",     32'(addr),       1);
    tick();
    check("stall_pc_a",  32'(pc),         32'hA);
    check("stall_ret5",  32'(retired),    5);
    check("stall_exit",  32'(exec_valid), 0);

    // Take pc to 4'hF, then wrap it back to 4'h0
    do_instr("to_f",  8'h00, 4'hF, 1'b0, 1'b0, 1'b1);
    do_instr("wrap0", 8'h13, 4'h0, 1'b1, 1'b0, 1'b0);
    check("wrap_ret", 32'(retired), 7);

    // HALT opcode
    imem_ack  = 1'b1;
    imem_data = 8'hF0;
    next_pc   = 4'h9;
    tick();
    imem_ack = 1'b0;
    check("hlt_dec_exec", 32'(exec_valid), 0);
    tick();
    check("hlt_halted", 32'(halted),   1);
    check("hlt_req",    32'(imem_req), 0);
    check("hlt_add",    32'(add),      0);
    imem_ack  = 1'b1;
    imem_data = 8'h15;
    for (int i = 0; i < 4; i++) tick();
    imem_ack = 1'b0;
    check("hlt_pc",     32'(pc),         0);
    check("hlt_ret",    32'(retired),    7);
    check("hlt_exec",   32'(exec_valid), 0);
    check("hlt_stay",   32'(halted),     1);
    check("hlt_noerr",  32'(fetch_err),  0);

    // Reset asserted during a stalled EXEC, with retired at 3
    do_reset();
    quiet_instr(8'h00, 4'h1);
    quiet_instr(8'h00, 4'h2);
    quiet_instr(8'h00, 4'h3);
    check("sr_ret3", 32'(retired), 3);
    imem_ack  = 1'b1;
    imem_data = 8'h11;
    next_pc   = 4'h9;
    tick();
    imem_ack = 1'b0;
    stall    = 1'b1;
    tick();
    tick();
    check("sr_stalled", 32'(exec_valid), 1);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    check("sr_pc",   32'(pc),         0);
    check("sr_ret",  32'(retired),    0);
    check("sr_req",  32'(imem_req),   1);
    check("sr_exec", 32'(exec_valid), 0);
    check("sr_add",  32'(add),        0);

    // Ack timeout: 8 FETCH cycles without an ack must fault
    for (int i = 0; i < 7; i++) tick();
    check("to7_halt", 32'(halted),    0);
    check("to7_err",  32'(fetch_err), 0);
    check("to7_req",  32'(imem_req),  1);
    tick();
    check("to8_halt", 32'(halted),    1);
    check("to8_err",  32'(fetch_err), 1);
    check("to8_pc",   32'(pc),        0);
    imem_ack  = 1'b1;
    imem_data = 8'h15;
    tick();
    tick();
    imem_ack = 1'b0;
    check("to_late_halt", 32'(halted),    1);
    check("to_late_err",  32'(fetch_err), 1);
    check("to_late_add",  32'(add),       0);
    check("to_late_ret",  32'(retired),   0);
    do_reset();
    check("to_rst_err",   32'(fetch_err), 0);
    check("to_rst_halt",  32'(halted),    0);

    // The wait counter clears on each FETCH entry. An ack in the 8th cycle still succeeds.
    for (int i = 0; i < 5; i++) tick();
    quiet_instr(8'h00, 4'h1);
    for (int i = 0; i < 7; i++) tick();
    check("edge_wait_halt", 32'(halted), 0);
    imem_ack  = 1'b1;
    imem_data = 8'h15;
    next_pc   = 4'h2;
    tick();
    imem_ack = 1'b0;
    check("edge_ack_add",  32'(add),       1);
    check("edge_ack_err",  32'(fetch_err), 0);
    check("edge_ack_halt", 32'(halted),    0);
    tick();
    tick();
    check("edge_pc",  32'(pc),      2);
    check("edge_ret", 32'(retired), 2);

    // retired saturates at 8'hFF
    for (int i = 0; i < 258; i++) quiet_instr(8'h00, 4'(i));
    check("sat_ret", 32'(retired), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
